// File: rtl/rv_emu_retire_chk.sv
// rtl/rv_emu_retire_chk.sv - lock-step emulator/CPU retire checker with masked field compare
// Optional macro RV_EMU_MISMATCH_LOG_EN adds first-mismatch pc/bits capture outputs.
module rv_emu_retire_chk #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter int HALT_ON_ERR = 1
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    enable_in,
    input  logic                    clr_in,
    input  logic                    emu_valid_in,
    output logic                    emu_ready_out,
    input  logic [3*XLEN+20:0]      emu_pkt_in,
    input  logic [7:0]              emu_chk_in,
    input  logic                    cpu_valid_in,
    input  logic [3*XLEN+20:0]      cpu_pkt_in,
    output logic                    cmp_valid_out,
    output logic [7:0]              mismatch_out,
    output logic [CNT_W-1:0]        err_cnt_out,
    output logic                    underflow_out,
    output logic                    halt_req_out,
    output logic [$clog2(DEPTH):0]  level_out
`ifdef RV_EMU_MISMATCH_LOG_EN
    ,
    output logic [XLEN-1:0]         first_err_pc_out,
    output logic [7:0]              first_err_bits_out
`endif
);

    localparam int PKT_W   = 3*XLEN + 21;
    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = AW + 1;
    localparam int ENT_W   = PKT_W + 8;
    localparam int O_GWR   = XLEN;
    localparam int O_GADDR = XLEN + 1;
    localparam int O_GDATA = XLEN + 6;
    localparam int O_CWR   = 2*XLEN + 6;
    localparam int O_CADDR = 2*XLEN + 7;
    localparam int O_CDATA = 2*XLEN + 19;
    localparam int O_MODE  = 3*XLEN + 19;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t            state;
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [PKT_W-1:0]  exp_pkt;
    logic [7:0]        exp_chk;
    logic [7:0]        diff;
    logic [7:0]        cmp_bits;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              underflow_evt;
    logic              err_evt;
    logic              halt_evt;
`ifdef RV_EMU_MISMATCH_LOG_EN
    logic              first_seen;
`endif

    always_comb begin
        full          = (level_out == LW'(DEPTH));
        empty         = (level_out == '0);
        emu_ready_out = !full;
        push          = emu_valid_in && !full;
        pop           = cpu_valid_in && (state == RUN) && !empty;
        underflow_evt = cpu_valid_in && (state == RUN) && empty;
        halt_evt      = (HALT_ON_ERR != 0) && cmp_valid_out && (mismatch_out != 8'd0);
        halt_req_out  = (state == HALT);

        exp_pkt = mem[rd_ptr][PKT_W-1:0];
        exp_chk = mem[rd_ptr][ENT_W-1:PKT_W];
        diff    = '0;
        diff[0] = exp_pkt[XLEN-1:0]           != cpu_pkt_in[XLEN-1:0];
        diff[1] = exp_pkt[O_GWR]              != cpu_pkt_in[O_GWR];
        diff[2] = exp_pkt[O_GADDR +: 5]       != cpu_pkt_in[O_GADDR +: 5];
        diff[3] = exp_pkt[O_GDATA +: XLEN]    != cpu_pkt_in[O_GDATA +: XLEN];
        diff[4] = exp_pkt[O_CWR]              != cpu_pkt_in[O_CWR];
        diff[5] = exp_pkt[O_CADDR +: 12]      != cpu_pkt_in[O_CADDR +: 12];
        diff[6] = exp_pkt[O_CDATA +: XLEN]    != cpu_pkt_in[O_CDATA +: XLEN];
        diff[7] = exp_pkt[O_MODE +: 2]        != cpu_pkt_in[O_MODE +: 2];
        cmp_bits = exp_chk & diff;

        // An underflow counts as an error just like a mismatching compare.
        err_evt = underflow_evt || (pop && (cmp_bits != 8'd0));
    end

    // Storage has no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= {emu_chk_in, emu_pkt_in};
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level_out     <= '0;
            cmp_valid_out <= 1'b0;
            mismatch_out  <= '0;
            err_cnt_out   <= '0;
            underflow_out <= 1'b0;
`ifdef RV_EMU_MISMATCH_LOG_EN
            first_seen         <= 1'b0;
            first_err_pc_out   <= '0;
            first_err_bits_out <= '0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_out <= level_out + LW'(1);
                2'b01:   level_out <= level_out - LW'(1);
                default: level_out <= level_out;
            endcase

            cmp_valid_out <= pop;
            if (pop) begin
                mismatch_out <= cmp_bits;
            end

            if (clr_in) begin
                err_cnt_out   <= '0;
                underflow_out <= 1'b0;
`ifdef RV_EMU_MISMATCH_LOG_EN
                first_seen         <= 1'b0;
                first_err_pc_out   <= '0;
                first_err_bits_out <= '0;
`endif
            end else begin
                if (underflow_evt) begin
                    underflow_out <= 1'b1;
                end
                if (err_evt && (err_cnt_out != '1)) begin
                    err_cnt_out <= err_cnt_out + CNT_W'(1);
                end
`ifdef RV_EMU_MISMATCH_LOG_EN
                if (pop && (cmp_bits != 8'd0) && !first_seen) begin
                    first_seen         <= 1'b1;
                    first_err_pc_out   <= exp_pkt[XLEN-1:0];
                    first_err_bits_out <= cmp_bits;
                end
`endif
            end

            if (!enable_in) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    state <= RUN;
                    RUN:     if (halt_evt && !clr_in) state <= HALT;
                    HALT:    if (clr_in) state <= RUN;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv_emu_retire_chk.sv
// tb/tb_rv_emu_retire_chk.sv - directed self-checking bench for rv_emu_retire_chk
module tb_rv_emu_retire_chk;

    typedef logic [116:0] pkt_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, clr, ev, cv;
    pkt_t       epkt, cpkt;
    logic [7:0] echk;
    logic       ready, cmpv, unf, halt;
    logic [7:0] mm;
    logic [15:0] ecnt;
    logic [3:0] lvl;

    logic       b_en, b_clr, b_ev, b_cv;
    pkt_t       b_epkt, b_cpkt;
    logic [7:0] b_echk;
    logic       b_ready, b_cmpv, b_unf, b_halt;
    logic [7:0] b_mm;
    logic [1:0] b_ecnt;
    logic [3:0] b_lvl;
`ifdef RV_EMU_MISMATCH_LOG_EN
    logic [31:0] a_fpc, b_fpc;
    logic [7:0]  a_fbits, b_fbits;
`endif

    int checks = 0;
    int errors = 0;

    rv_emu_retire_chk dut (
        .clk_in(clk), .reset_in(rst), .enable_in(en), .clr_in(clr),
        .emu_valid_in(ev), .emu_ready_out(ready), .emu_pkt_in(epkt), .emu_chk_in(echk),
        .cpu_valid_in(cv), .cpu_pkt_in(cpkt), .cmp_valid_out(cmpv), .mismatch_out(mm),
        .err_cnt_out(ecnt), .underflow_out(unf), .halt_req_out(halt), .level_out(lvl)
`ifdef RV_EMU_MISMATCH_LOG_EN
        , .first_err_pc_out(a_fpc), .first_err_bits_out(a_fbits)
`endif
    );

    rv_emu_retire_chk #(.CNT_W(2), .HALT_ON_ERR(0)) dut_b (
        .clk_in(clk), .reset_in(rst), .enable_in(b_en), .clr_in(b_clr),
        .emu_valid_in(b_ev), .emu_ready_out(b_ready), .emu_pkt_in(b_epkt), .emu_chk_in(b_echk),
        .cpu_valid_in(b_cv), .cpu_pkt_in(b_cpkt), .cmp_valid_out(b_cmpv), .mismatch_out(b_mm),
        .err_cnt_out(b_ecnt), .underflow_out(b_unf), .halt_req_out(b_halt), .level_out(b_lvl)
`ifdef RV_EMU_MISMATCH_LOG_EN
        , .first_err_pc_out(b_fpc), .first_err_bits_out(b_fbits)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pkt_t mk(input logic [31:0] pc, input logic gwr, input logic [4:0] gaddr,
                                input logic [31:0] gdata, input logic cwr, input logic [11:0] caddr,
                                input logic [31:0] cdata, input logic [1:0] mode);
        return {mode, cdata, caddr, cwr, gdata, gaddr, gwr, pc};
    endfunction

    function automatic pkt_t mkd(input logic [31:0] pc, input logic [31:0] gdata);
        return mk(pc, 1'b1, 5'd3, gdata, 1'b0, 12'h300, 32'h0, 2'd3);
    endfunction

    task automatic push_a(input pkt_t p, input logic [7:0] c);
        ev = 1'b1; epkt = p; echk = c;
        tick();
        ev = 1'b0;
    endtask

    task automatic retire_a(input pkt_t p);
        cv = 1'b1; cpkt = p;
        tick();
        cv = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int np, nr;
        logic pushing, popping;
        rst = 0; en = 0; clr = 0; ev = 0; cv = 0; epkt = '0; cpkt = '0; echk = '0;
        b_en = 0; b_clr = 0; b_ev = 0; b_cv = 0; b_epkt = '0; b_cpkt = '0; b_echk = '0;
        tick(); tick();
        check("rst_ready", ready, 1);
        check("rst_cmpv", cmpv, 0);
        check("rst_mm", mm, 0);
        check("rst_ecnt", ecnt, 0);
        check("rst_unf", unf, 0);
        check("rst_halt", halt, 0);
        check("rst_lvl", lvl, 0);
        rst = 1; en = 1;
        tick();

        // three matching retires
        for (int i = 0; i < 3; i++) push_a(mkd(32'h100 + 4*i, 32'h5), 8'hFF);
        check("t1_lvl3", lvl, 3);
        check("t1_cmpv_pre", cmpv, 0);
        for (int i = 0; i < 3; i++) begin
            retire_a(mkd(32'h100 + 4*i, 32'h5));
            check("t1_cmpv", cmpv, 1);
            check("t1_mm", mm, 0);
        end
        tick();
        check("t1_pulse", cmpv, 0);
        check("t1_lvl0", lvl, 0);
        check("t1_ecnt", ecnt, 0);

        // gpr_data mismatch halts
        push_a(mkd(32'h10C, 32'h5), 8'hFF);
        retire_a(mkd(32'h10C, 32'h6));
        check("t2_cmpv", cmpv, 1);
        check("t2_mm", mm, 8'h08);
        check("t2_ecnt", ecnt, 1);
        check("t2_halt_pre", halt, 0);
        tick();
        check("t2_halt", halt, 1);
        push_a(mkd(32'h110, 32'h5), 8'hFF);
        cv = 1; cpkt = mkd(32'h110, 32'h5);
        tick(); tick();
        cv = 0;
        check("t2_ign_lvl", lvl, 1);
        check("t2_ign_cmpv", cmpv, 0);
        check("t2_ign_unf", unf, 0);
        clr = 1; tick(); clr = 0;
        check("t2_clr_halt", halt, 0);
        check("t2_clr_ecnt", ecnt, 0);
        retire_a(mkd(32'h110, 32'h5));
        check("t2_run_cmpv", cmpv, 1);
        check("t2_run_mm", mm, 0);
        check("t2_run_lvl", lvl, 0);

        // masked-out data mismatch, then multi-field mask
        push_a(mkd(32'h114, 32'h5), 8'hF7);
        retire_a(mkd(32'h114, 32'h6));
        check("t3_cmpv", cmpv, 1);
        check("t3_mm", mm, 0);
        check("t3_ecnt", ecnt, 0);
        tick();
        check("t3_halt", halt, 0);
        push_a(mk(32'h118, 1'b1, 5'd3, 32'h5, 1'b0, 12'h300, 32'h0, 2'd3), 8'h5E);
        retire_a(mk(32'h118, 1'b0, 5'd4, 32'h5, 1'b1, 12'h301, 32'h7, 2'd1));
        check("t3_fields_mm", mm, 8'h56);
        check("t3_fields_ecnt", ecnt, 1);
        tick();
        check("t3_fields_halt", halt, 1);
        clr = 1; tick(); clr = 0;
        check("t3_clr_ecnt", ecnt, 0);

        // fill, hold ninth, stream 20 packets through for pointer wrap
        for (int i = 0; i < 8; i++) push_a(mkd(32'h300 + 4*i, i), 8'hFF);
        check("t4_ready", ready, 0);
        check("t4_lvl8", lvl, 8);
        ev = 1; epkt = mkd(32'h300 + 4*8, 8); echk = 8'hFF;
        tick();
        check("t4_ninth_held", lvl, 8);
        np = 8; nr = 0;
        for (int k = 0; k < 40 && nr < 20; k++) begin
            pushing = ev && ready;
            popping = (nr < np);
            cv = popping; cpkt = mkd(32'h300 + 4*nr, nr);
            tick();
            if (pushing) np++;
            if (popping) begin
                check("t4_cmpv", cmpv, 1);
                check("t4_mm", mm, 0);
                nr++;
            end
            check("t4_lvl", lvl, np - nr);
            ev = (np < 20); epkt = mkd(32'h300 + 4*np, np);
        end
        cv = 0; ev = 0;
        check("t4_drained", nr, 20);
        check("t4_ecnt", ecnt, 0);

        // underflow with same-cycle push
        cv = 1; ev = 1; epkt = mkd(32'h400, 1); echk = 8'hFF;
        tick();
        cv = 0; ev = 0;
        check("t5_unf", unf, 1);
        check("t5_ecnt", ecnt, 1);
        check("t5_cmpv", cmpv, 0);
        check("t5_lvl", lvl, 1);
        check("t5_halt", halt, 0);
        tick();
        check("t5_sticky", unf, 1);
        retire_a(mkd(32'h400, 1));
        check("t5_queued_cmpv", cmpv, 1);
        check("t5_queued_mm", mm, 0);
        clr = 1; tick(); clr = 0;
        check("t5_clr_unf", unf, 0);
        check("t5_clr_ecnt", ecnt, 0);

        // IDLE ignores retires but accepts pushes
        en = 0; tick();
        cv = 1; cpkt = mkd(32'h500, 2);
        push_a(mkd(32'h500, 2), 8'hFF);
        tick();
        cv = 0;
        check("t6_lvl", lvl, 1);
        check("t6_unf", unf, 0);
        check("t6_cmpv", cmpv, 0);
        en = 1; tick();
        retire_a(mkd(32'h500, 2));
        check("t6_cmpv_run", cmpv, 1);
        check("t6_lvl0", lvl, 0);

        // reset mid-operation
        retire_a(mkd(32'h0, 0));
        check("t7_unf_pre", unf, 1);
        push_a(mkd(32'h600, 3), 8'hFF);
        push_a(mkd(32'h604, 3), 8'hFF);
        cv = 1; cpkt = mkd(32'h600, 3); rst = 0;
        tick();
        cv = 0;
        check("t7_lvl", lvl, 0);
        check("t7_cmpv", cmpv, 0);
        check("t7_ready", ready, 1);
        check("t7_unf", unf, 0);
        check("t7_ecnt", ecnt, 0);
        rst = 1; tick();

        // no-halt instance: two mismatches, saturation, log capture
        b_en = 1; tick();
        b_ev = 1; b_epkt = mkd(32'h200, 1); b_echk = 8'h01; tick();
        b_epkt = mkd(32'h204, 1); b_echk = 8'h80; tick();
        b_ev = 0;
        b_cv = 1; b_cpkt = mkd(32'h201, 1); tick();
        check("t8_mm1", b_mm, 8'h01);
        check("t8_ecnt1", b_ecnt, 1);
        b_cpkt = mk(32'h204, 1'b1, 5'd3, 32'h1, 1'b0, 12'h300, 32'h0, 2'd0); tick();
        b_cv = 0;
        check("t8_mm2", b_mm, 8'h80);
        check("t8_ecnt2", b_ecnt, 2);
        tick();
        check("t8_nohalt", b_halt, 0);
`ifdef RV_EMU_MISMATCH_LOG_EN
        check("t8_fpc", b_fpc, 32'h200);
        check("t8_fbits", b_fbits, 8'h01);
`endif
        b_cv = 1; tick(); tick(); b_cv = 0;
        check("t8_sat", b_ecnt, 3);
        check("t8_unf", b_unf, 1);
        b_clr = 1; tick(); b_clr = 0;
        check("t8_clr_ecnt", b_ecnt, 0);
`ifdef RV_EMU_MISMATCH_LOG_EN
        check("t8_clr_fpc", b_fpc, 0);
        check("t8_clr_fbits", b_fbits, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_emu_retire_chk.md
Name: rv_emu_retire_chk

Overview:
- Lock-step checker between the RV emulator and the CPU retire stage.
- The emulator pushes expected retire packets, each with a per-instruction check mask, into a parametrised FIFO.
- Each CPU retire pops one entry and compares it field by field, but only for the fields whose mask bit is set.
- Reports per-field mismatches, an error count and a halt request. Sits in the sim/FPGA verification harness beside the emulator.

Parameters:
- XLEN, 32, data/PC width.
- DEPTH, 8, FIFO entries; power of 2, 2..64.
- CNT_W, 16, error-counter width.
- HALT_ON_ERR, 1, 1 = enter HALT on the first mismatch; 0 = keep running.

Ports:
- clk_in  in  1  clock.
- reset_in  in  1  synchronous, active-low reset.
- enable_in  in  1  checker enable; 0 forces IDLE.
- clr_in  in  1  clears counters, sticky flags and HALT.
- emu_valid_in  in  1  emulator packet valid.
- emu_ready_out  out  1  FIFO can accept.
- emu_pkt_in  in  PKT_W  expected packet.
- emu_chk_in  in  8  check mask.
- cpu_valid_in  in  1  CPU retired one instruction (no backpressure).
- cpu_pkt_in  in  PKT_W  actual packet.
- cmp_valid_out  out  1  comparison result valid.
- mismatch_out  out  8  per-field mismatch bits.
- err_cnt_out  out  CNT_W  mismatching-compare count.
- underflow_out  out  1  sticky: CPU retired with FIFO empty.
- halt_req_out  out  1  state==HALT.
- level_out  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Packet layout, LSB first: pc[XLEN], gpr_wr, gpr_addr[5], gpr_data[XLEN], csr_wr, csr_addr[12], csr_wr_data[XLEN], mode[2]. PKT_W = 3*XLEN+21.
- Mask and mismatch bit order: 0 pc, 1 gpr_wr, 2 gpr_addr, 3 gpr_data, 4 csr_wr, 5 csr_addr, 6 csr_wr_data, 7 mode.
- Reset (reset_in=0 at a clock edge) and clr_in:
  - state=IDLE on reset; clr_in leaves state unchanged except HALT returns to RUN.
  - FIFO emptied (reset only; clr_in does not flush).
  - All outputs 0, except emu_ready_out=1 after reset.
  - Reset mid-operation discards all entries and any in-flight compare.
- FIFO push: occurs when emu_valid_in && emu_ready_out. emu_ready_out = !full. There is no full-bypass.
- FIFO pop: occurs when cpu_valid_in && state==RUN && !empty.
- Simultaneous push and pop: occupancy unchanged; pointers wrap modulo DEPTH.
- Empty FIFO: no bypass. cpu_valid_in with an empty FIFO in RUN sets underflow_out, does not compare or pop, and increments err_cnt_out. A packet pushed in the same cycle remains queued.
- Compare: registered, latency 1.
  - Cycle N pop produces cmp_valid_out=1 in cycle N+1.
  - mismatch_out[i] = chk[i] & (exp_field_i != act_field_i).
  - mismatch_out holds its value until the next compare; cmp_valid_out pulses for one cycle.
  - err_cnt_out increments by 1 per compare with any mismatch bit set. It saturates at all-ones and never wraps.
- State machine:
  - IDLE to RUN when enable_in=1.
  - RUN to IDLE when enable_in=0; the FIFO is retained.
  - RUN to HALT in the cycle cmp_valid_out shows a nonzero mismatch_out, when HALT_ON_ERR=1.
  - HALT to RUN on clr_in.
  - HALT or RUN to IDLE when enable_in=0.
- In IDLE and HALT: no pops and cpu_valid_in is ignored (no underflow). Pushes are still accepted until full.
- clr_in has priority over the same-cycle counter increment. clr_in in a cycle with a mismatch compare leaves the counter at 0 and state RUN.

Optional Feature:
- Macro: RV_EMU_MISMATCH_LOG_EN.
- When defined, two extra outputs are present:
  - first_err_pc_out [XLEN]: expected pc of the first mismatching compare since reset or clr_in.
  - first_err_bits_out [8]: mismatch bits of that same compare.
- Both are captured once and held; both are 0 after reset or clr_in.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, enable; push 3 packets (pc 0x100, 0x104, 0x108; mask 0xFF); 3 matching CPU retires -> 3 cmp_valid pulses, each one cycle after its pop; mismatch_out=0; err_cnt_out=0; level_out ends at 0.
- Expected gpr_data 0x5, actual 0x6, mask 0xFF, HALT_ON_ERR=1 -> mismatch_out=0x08; err_cnt_out=1; halt_req_out=1 next cycle; further retires ignored; clr_in -> RUN with err_cnt_out=0.
- Same data mismatch but mask bit 3 cleared (0xF7) -> mismatch_out=0x00; err_cnt_out=0.
- Push DEPTH=8 packets with no retires -> emu_ready_out=0 and level_out=8. Ninth push is held. Push and retire in the same cycle keeps level_out at 7 after the first pop frees space; pointer wrap verified over 20 packets.
- cpu_valid_in with an empty FIFO in RUN -> underflow_out=1 sticky; err_cnt_out=1; no cmp_valid_out.
- RV_EMU_MISMATCH_LOG_EN: mismatches at pc 0x200 (bits 0x01) then 0x204 (bits 0x80), HALT_ON_ERR=0 -> first_err_pc_out=0x200 and first_err_bits_out=0x01 held; err_cnt_out=2.
